sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter WAIT_CYCLES, default 1, extra access cycles beyond the minimum; SHALL accept 0..15.
REQ-004 Derived BE_W = DATA_W/8; counter width SHALL be max(1, clog2(WAIT_CYCLES+1)).
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_i  in  1  access request, qualified by ready_o.
REQ-008 we_i  in  1  1 = write, 0 = read.
REQ-009 addr_i  in  ADDR_W  word address.
REQ-010 be_i  in  BE_W  active-high byte enables (writes only).
REQ-011 wdata_i  in  DATA_W  write data.
REQ-012 ready_o  out  1  controller idle, can accept a request.
REQ-013 done_o  out  1  one-cycle pulse on access completion.
REQ-014 rdata_o  out  DATA_W  registered read data, valid when done_o follows a read.
REQ-015 ram_addr_o  out  ADDR_W  SRAM address.
REQ-016 ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  active-low SRAM strobes.
REQ-017 ram_be_n_o  out  BE_W  active-low SRAM byte enables.
REQ-018 ram_data_io  inout  DATA_W  SRAM data bus.

Function
REQ-019 Handshake: a request SHALL be accepted on a rising edge where req_i=1 and ready_o=1. At that edge, addr_i, we_i, be_i and wdata_i SHALL be registered, and later input changes SHALL be ignored until done_o.
REQ-020 ready_o SHALL be 1 exactly when state=IDLE and rst=0.
REQ-021 State machine states: IDLE, READ, WSETUP, WPULSE, WHOLD.
REQ-022 Transitions:
- IDLE -> READ on an accepted read; IDLE -> WSETUP on an accepted write.
- READ -> IDLE after WAIT_CYCLES+1 cycles.
- WSETUP -> WPULSE after 1 cycle.
- WPULSE -> WHOLD after WAIT_CYCLES+1 cycles.
- WHOLD -> IDLE after 1 cycle.
REQ-023 In IDLE, the pins SHALL be:
- ce_n=1, oe_n=1, we_n=1;
- be_n all 1;
- ram_data_io high-Z;
- ram_addr_o holding its last value.
REQ-024 In READ, the pins SHALL be:
- ce_n=0, oe_n=0, we_n=1;
- be_n all 0;
- ram_addr_o = registered address;
- ram_data_io high-Z.
REQ-025 On the final READ edge, rdata_o SHALL capture ram_data_io; rdata_o SHALL otherwise hold its value.
REQ-026 In WSETUP, WPULSE and WHOLD, the pins SHALL be:
- ce_n=0, oe_n=1;
- ram_addr_o = registered address;
- be_n = ~registered be;
- ram_data_io driven with registered wdata.
REQ-027 we_n SHALL be 0 only in WPULSE.
REQ-028 ram_data_io SHALL never be driven while oe_n=0; the mandatory IDLE cycle between accesses provides bus turnaround.
REQ-029 done_o SHALL be 1 for exactly the first IDLE cycle after READ or WHOLD, and 0 otherwise.
REQ-030 Latency from the acceptance edge to the done_o cycle: read = WAIT_CYCLES+2 cycles; write = WAIT_CYCLES+4 cycles.
REQ-031 A new request accepted in the done_o cycle SHALL be legal (back-to-back); throughput SHALL be one access per (latency) cycles.
REQ-032 A write with be_i all zero SHALL execute the full write sequence with be_n all 1 and SHALL assert done_o.
REQ-033 WAIT_CYCLES=0 SHALL give a 1-cycle READ and a 1-cycle WPULSE.
REQ-034 All SRAM strobe outputs SHALL be registered, with no combinational path from req_i to any ram_* pin.

Reset
REQ-035 While rst=1 at a rising edge, the next state SHALL be:
- state IDLE, wait counter 0;
- ce_n, oe_n, we_n = 1; be_n all 1;
- ram_addr_o 0; ram_data_io high-Z;
- rdata_o 0; done_o 0; ready_o 0.
REQ-036 rst asserted mid-access SHALL abort the access. Strobes SHALL be deasserted on the next edge, no done_o SHALL be issued, and rdata_o SHALL be cleared.

Verification
REQ-037 WAIT_CYCLES=1, read addr 0x00010, SRAM model returns 0xDEADBEEF -> oe_n low for 2 cycles, done_o 3 cycles after acceptance, rdata_o=0xDEADBEEF.
REQ-038 WAIT_CYCLES=1, write addr 0x00020, data 0x12345678, be_i=4'b0101 -> we_n low for exactly 2 cycles, be_n=4'b1010, model bytes 0 and 2 updated, done_o 5 cycles after acceptance.
REQ-039 Write then read of the same address issued back-to-back -> read accepted in the write's done_o cycle, read returns the written bytes, bus never driven while oe_n=0.
REQ-040 WAIT_CYCLES=0 and WAIT_CYCLES=15 builds, random read/write traffic against a reference memory -> all data match and latencies follow REQ-030.
REQ-041 rst pulsed during WPULSE -> we_n=1 and data high-Z on the next edge, no done_o, ready_o=1 one cycle after rst falls.
REQ-042 req_i and addr_i changed while busy -> ignored, and the access uses the values captured at acceptance.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Asynchronous SRAM port controller.
// Accepts one read or write request at a time and sequences the active-low
// SRAM strobes. Reads hold OE low for WAIT_CYCLES+1 cycles. Writes use a
// setup cycle, a WE pulse of WAIT_CYCLES+1 cycles and a hold cycle.
// Every SRAM pin is driven from a flop. The mandatory IDLE cycle between
// accesses provides bus turnaround.
module sram_port_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic                  ram_ce_n_o,
    output logic                  ram_oe_n_o,
    output logic                  ram_we_n_o,
    output logic [DATA_W/8-1:0]   ram_be_n_o,
    inout  wire  [DATA_W-1:0]     ram_data_io
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WSETUP,
        WPULSE,
        WHOLD
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                accept;
    logic                done_nxt;
    logic                cap_rdata;
    logic                ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic [BE_W-1:0]     be_n_nxt;
    logic                drive_nxt;
    logic                drive_en;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;

    // Idle and out of reset is the only condition in which a request is taken.
    assign ready_o = (state == IDLE) && !rst;

    // The data bus is driven only in the write states, where OE is high.
    assign ram_data_io = drive_en ? wdata_q : {DATA_W{1'bz}};

    // Next-state, wait counter and next SRAM pin values.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        cap_rdata = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                if (req_i) begin
                    accept    = 1'b1;
                    state_nxt = we_i ? WSETUP : READ;
                end
            end
            READ: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    cap_rdata = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WSETUP: begin
                state_nxt = WPULSE;
            end
            WPULSE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = WHOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WHOLD: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Pin values for the state being entered, so the pins are flop outputs.
        ce_n_nxt  = (state_nxt == IDLE);
        oe_n_nxt  = (state_nxt != READ);
        we_n_nxt  = (state_nxt != WPULSE);
        drive_nxt = (state_nxt == WSETUP) || (state_nxt == WPULSE) ||
                    (state_nxt == WHOLD);
        if (state_nxt == READ) begin
            be_n_nxt = '0;
        end else if (drive_nxt) begin
            be_n_nxt = accept ? ~be_i : ~be_q;
        end else begin
            be_n_nxt = '1;
        end
    end

    // State, request capture, registered SRAM pins and read data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            ram_addr_o <= '0;
            ram_ce_n_o <= 1'b1;
            ram_oe_n_o <= 1'b1;
            ram_we_n_o <= 1'b1;
            ram_be_n_o <= '1;
            drive_en   <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            done_o     <= done_nxt;
            ram_ce_n_o <= ce_n_nxt;
            ram_oe_n_o <= oe_n_nxt;
            ram_we_n_o <= we_n_nxt;
            ram_be_n_o <= be_n_nxt;
            drive_en   <= drive_nxt;
            if (accept) begin
                ram_addr_o <= addr_i;
                be_q       <= be_i;
                wdata_q    <= wdata_i;
            end
            if (cap_rdata) begin
                rdata_o <= ram_data_io;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl. Two instances, WAIT_CYCLES=0 and
// WAIT_CYCLES=1, share the request inputs. Each request line is gated by
// sel, and each instance has its own simple SRAM model. Expected values are
// hand-computed constants.
module tb_sram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        sel = 1'b1;
    logic        we_i = 1'b0;
    logic [19:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;

    logic        ready0, done0, ce0, oe0, we0;
    logic [31:0] rdata0;
    logic [19:0] addr0;
    logic [3:0]  be_n0;
    wire  [31:0] data0;
    logic        ready1, done1, ce1, oe1, we1;
    logic [31:0] rdata1;
    logic [19:0] addr1;
    logic [3:0]  be_n1;
    wire  [31:0] data1;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    int checks = 0;
    int errors = 0;
    int bus_bad = 0;
    int lat, oe_low, we_low, addr_bad;
    logic [3:0] wr_be_n;

    wire req0 = req & ~sel;
    wire req1 = req & sel;

    wire        ready_s = sel ? ready1 : ready0;
    wire        done_s  = sel ? done1  : done0;
    wire        ce_s    = sel ? ce1    : ce0;
    wire        oe_s    = sel ? oe1    : oe0;
    wire        we_s    = sel ? we1    : we0;
    wire [31:0] rdata_s = sel ? rdata1 : rdata0;
    wire [19:0] addr_s  = sel ? addr1  : addr0;
    wire [3:0]  be_n_s  = sel ? be_n1  : be_n0;

    sram_port_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .ready_o(ready0), .done_o(done0),
        .rdata_o(rdata0), .ram_addr_o(addr0), .ram_ce_n_o(ce0),
        .ram_oe_n_o(oe0), .ram_we_n_o(we0), .ram_be_n_o(be_n0),
        .ram_data_io(data0)
    );

    sram_port_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_i(req1), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .ready_o(ready1), .done_o(done1),
        .rdata_o(rdata1), .ram_addr_o(addr1), .ram_ce_n_o(ce1),
        .ram_oe_n_o(oe1), .ram_we_n_o(we1), .ram_be_n_o(be_n1),
        .ram_data_io(data1)
    );

    always #5 clk = ~clk;

    // SRAM models: drive the bus while CE and OE are low, write enabled bytes while WE is low.
    assign data0 = (!ce0 && !oe0) ? mem0[addr0[7:0]] : 32'bz;
    assign data1 = (!ce1 && !oe1) ? mem1[addr1[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (!ce0 && !we0)
            for (int i = 0; i < 4; i++)
                if (!be_n0[i]) mem0[addr0[7:0]][8*i +: 8] = data0[8*i +: 8];
        if (!ce1 && !we1)
            for (int i = 0; i < 4; i++)
                if (!be_n1[i]) mem1[addr1[7:0]][8*i +: 8] = data1[8*i +: 8];
    end

    // While OE is low, the bus must carry exactly what the SRAM drives.
    always @(negedge clk) begin
        if (!ce0 && !oe0 && (data0 !== mem0[addr0[7:0]])) bus_bad++;
        if (!ce1 && !oe1 && (data1 !== mem1[addr1[7:0]])) bus_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and return in its done_o cycle. Latency is counted
    // in cycles from the acceptance edge. With perturb set, the inputs are
    // scrambled and req is pulsed while the access is busy.
    task automatic access(input bit s, input bit w, input logic [19:0] a,
                          input logic [3:0] b, input logic [31:0] d, input bit perturb);
        sel = s; we_i = w; addr_i = a; be_i = b; wdata_i = d; req = 1'b1;
        #0;
        check("ready_before_accept", ready_s, 1);
        tick;
        req = 1'b0;
        if (perturb) begin
            addr_i = ~a; we_i = ~w; be_i = ~b; wdata_i = ~d;
        end
        lat = 1; oe_low = 0; we_low = 0; addr_bad = 0; wr_be_n = 4'h5;
        while (!done_s && lat < 40) begin
            if (!oe_s) oe_low++;
            if (!we_s) begin
                we_low++;
                wr_be_n = be_n_s;
            end
            if (addr_s !== a) addr_bad++;
            req = (perturb && lat == 1);
            tick;
            lat++;
        end
        req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem1[8'h10] = 32'hDEADBEEF;
        mem1[8'h20] = 32'hAABBCCDD;
        mem0[8'h10] = 32'h01234567;

        // Reset state.
        rst = 1'b1;
        tick;
        tick;
        check("rst_ready", ready1, 0);
        check("rst_ready_w0", ready0, 0);
        check("rst_ce_n", ce1, 1);
        check("rst_oe_n", oe1, 1);
        check("rst_we_n", we1, 1);
        check("rst_be_n", be_n1, 4'hF);
        check("rst_addr", addr1, 0);
        check("rst_rdata", rdata1, 0);
        check("rst_done", done1, 0);
        rst = 1'b0;
        #0;
        check("ready_after_rst", ready1, 1);
        tick;

        // Read, WAIT_CYCLES=1.
        access(1, 0, 20'h00010, 4'hF, 32'h0, 0);
        check("rd_latency", lat, 3);
        check("rd_oe_low", oe_low, 2);
        check("rd_we_low", we_low, 0);
        check("rd_addr", addr_bad, 0);
        check("rd_data", rdata1, 32'hDEADBEEF);
        tick;
        check("rd_done_pulse", done1, 0);
        check("rd_idle_oe_n", oe1, 1);

        // Write with byte enables 0101.
        access(1, 1, 20'h00020, 4'b0101, 32'h12345678, 0);
        check("wr_latency", lat, 5);
        check("wr_we_low", we_low, 2);
        check("wr_oe_low", oe_low, 0);
        check("wr_be_n", wr_be_n, 4'b1010);
        check("wr_mem", mem1[8'h20], 32'hAA34CC78);
        tick;
        check("wr_done_pulse", done1, 0);

        // Back-to-back write then read of the same address.
        access(1, 1, 20'h00030, 4'hF, 32'hCAFEF00D, 0);
        check("b2b_wr_latency", lat, 5);
        access(1, 0, 20'h00030, 4'hF, 32'h0, 0);
        check("b2b_rd_latency", lat, 3);
        check("b2b_rd_data", rdata1, 32'hCAFEF00D);
        tick;

        // Inputs changed while busy are ignored.
        access(1, 0, 20'h00010, 4'hF, 32'h0, 1);
        check("pert_rd_latency", lat, 3);
        check("pert_rd_addr", addr_bad, 0);
        check("pert_rd_data", rdata1, 32'hDEADBEEF);
        access(1, 1, 20'h00040, 4'hF, 32'h0F0F0F0F, 1);
        check("pert_wr_latency", lat, 5);
        check("pert_wr_addr", addr_bad, 0);
        check("pert_wr_mem", mem1[8'h40], 32'h0F0F0F0F);
        check("pert_other_addr", mem1[8'hBF], 32'h0);
        tick;

        // Write with no byte enables runs the full sequence and leaves memory unchanged.
        access(1, 1, 20'h00020, 4'h0, 32'hFFFFFFFF, 0);
        check("be0_latency", lat, 5);
        check("be0_we_low", we_low, 2);
        check("be0_be_n", wr_be_n, 4'hF);
        check("be0_mem", mem1[8'h20], 32'hAA34CC78);
        tick;

        // Reset during WPULSE aborts the write.
        sel = 1'b1; we_i = 1'b1; addr_i = 20'h00050; be_i = 4'hF;
        wdata_i = 32'h11111111; req = 1'b1;
        tick;
        req = 1'b0;
        tick;
        check("abort_in_wpulse", we1, 0);
        rst = 1'b1;
        tick;
        check("abort_we_n", we1, 1);
        check("abort_ce_n", ce1, 1);
        check("abort_be_n", be_n1, 4'hF);
        check("abort_done", done1, 0);
        check("abort_ready", ready1, 0);
        check("abort_rdata", rdata1, 0);
        rst = 1'b0;
        tick;
        check("abort_ready_after", ready1, 1);
        check("abort_no_done", done1, 0);

        // WAIT_CYCLES=0 build.
        access(0, 0, 20'h00010, 4'hF, 32'h0, 0);
        check("w0_rd_latency", lat, 2);
        check("w0_rd_oe_low", oe_low, 1);
        check("w0_rd_data", rdata0, 32'h01234567);
        access(0, 1, 20'h00011, 4'b1100, 32'h89ABCDEF, 0);
        check("w0_wr_latency", lat, 4);
        check("w0_wr_we_low", we_low, 1);
        check("w0_wr_mem", mem0[8'h11], 32'h89AB0000);
        access(0, 0, 20'h00011, 4'hF, 32'h0, 0);
        check("w0_b2b_rd_latency", lat, 2);
        check("w0_b2b_rd_data", rdata0, 32'h89AB0000);
        tick;
        check("w0_done_pulse", done0, 0);

        check("bus_contention", bus_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
